// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and payload-drain signal bundle for uart_cmd_parser.
// The slave modport is the parser's view and the master modport is the environment's view.
interface uart_cmd_parser_if;
  logic       i_rx_byte_rdy;
  logic [7:0] i_rx_byte;
  logic       o_frame_valid;
  logic [7:0] o_cmd;
  logic [7:0] o_len;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_ready;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_overrun;
  logic       o_busy;

  modport slave (
    input  i_rx_byte_rdy, i_rx_byte, i_data_ready,
    output o_frame_valid, o_cmd, o_len, o_data, o_data_valid,
           o_err, o_err_code, o_overrun, o_busy
  );

  modport master (
    output i_rx_byte_rdy, i_rx_byte, i_data_ready,
    input  o_frame_valid, o_cmd, o_len, o_data, o_data_valid,
           o_err, o_err_code, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frame parser: SYNC, CMD, LEN, payload, XOR checksum. Accepted payloads are
// buffered and then drained through a valid/ready port, with an inter-byte timeout.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 16384
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_cmd_parser_if.slave bus
);
  localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             CW        = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0]     ERR_CHK   = 2'b01;
  localparam logic [1:0]     ERR_LEN   = 2'b10;
  localparam logic [1:0]     ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    chk_q, chk_d, cmd_q, cmd_d, len_q, len_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_inc_s;
  logic [7:0]    cmd_out_q, cmd_out_d, len_out_q, len_out_d, data_q, data_d;
  logic          frame_valid_q, frame_valid_d, data_valid_q, data_valid_d;
  logic          err_q, err_d, overrun_q, overrun_d, busy_q, busy_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          mem_we_s;
  logic [7:0]    mem_q [MAX_LEN];

  assign rd_inc_s = rd_idx_q + IW'(1);

  // Next-state and output computation for the parse/drain FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    chk_d         = chk_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    cmd_out_d     = cmd_out_q;
    len_out_d     = len_out_q;
    data_d        = data_q;
    data_valid_d  = data_valid_q;
    err_code_d    = err_code_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    overrun_d     = 1'b0;
    mem_we_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_byte_rdy && (bus.i_rx_byte == SYNC_BYTE)) begin
          state_d = S_CMD;
          chk_d   = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (bus.i_rx_byte_rdy) begin
          cmd_d   = bus.i_rx_byte;
          chk_d   = chk_step(chk_q, bus.i_rx_byte);
          state_d = S_LEN;
        end else begin
          state_d = S_CMD;
        end
      end
      S_LEN: begin
        if (bus.i_rx_byte_rdy) begin
          len_d = bus.i_rx_byte;
          chk_d = chk_step(chk_q, bus.i_rx_byte);
          if (bus.i_rx_byte > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_IDLE;
          end else if (bus.i_rx_byte == 8'h00) begin
            state_d = S_CHK;
          end else begin
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (bus.i_rx_byte_rdy) begin
          mem_we_s = 1'b1;
          chk_d    = chk_step(chk_q, bus.i_rx_byte);
          wr_idx_d = wr_idx_q + IW'(1);
          if (8'(wr_idx_q) == (len_q - 8'd1)) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (bus.i_rx_byte_rdy) begin
          if (bus.i_rx_byte == chk_q) begin
            frame_valid_d = 1'b1;
            cmd_out_d     = cmd_q;
            len_out_d     = len_q;
            if (len_q != 8'h00) begin
              // First payload byte is presented together with the frame_valid pulse.
              state_d      = S_DRAIN;
              data_valid_d = 1'b1;
              data_d       = mem_q[{IW{1'b0}}];
              rd_idx_d     = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = S_IDLE;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_DRAIN: begin
        overrun_d = bus.i_rx_byte_rdy;
        if (data_valid_q && bus.i_data_ready) begin
          if (8'(rd_idx_q) == (len_q - 8'd1)) begin
            data_valid_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            rd_idx_d = rd_inc_s;
            data_d   = mem_q[rd_inc_s];
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d      = S_IDLE;
        data_valid_d = 1'b0;
      end
    endcase

    // A byte strobe always wins over an expiring timeout.
    if ((state_q == S_CMD) || (state_q == S_LEN) ||
        (state_q == S_PAYLOAD) || (state_q == S_CHK)) begin
      if (bus.i_rx_byte_rdy) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d      = '0;
        err_d      = 1'b1;
        err_code_d = ERR_TMO;
        state_d    = S_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      chk_q         <= 8'h00;
      cmd_q         <= 8'h00;
      len_q         <= 8'h00;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      cmd_out_q     <= 8'h00;
      len_out_q     <= 8'h00;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chk_q         <= chk_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      cmd_out_q     <= cmd_out_d;
      len_out_q     <= len_out_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  // Payload storage; contents are meaningless outside an accepted frame, so no reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_q[wr_idx_q] <= bus.i_rx_byte;
    end
  end

  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_cmd         = cmd_out_q;
  assign bus.o_len         = len_out_q;
  assign bus.o_data        = data_q;
  assign bus.o_data_valid  = data_valid_q;
  assign bus.o_err         = err_q;
  assign bus.o_err_code    = err_code_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_busy        = busy_q;
endmodule
